// File: rtl/ama_riscv_inst_encoder_if.sv
// Encoder request/stream bundle: field-level encode requests in, packed words out, plus status.
// master drives requests and consumes the stream; slave is the encoder.
interface ama_riscv_inst_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_fmt;
  logic [6:0]    in_opc7;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_fn3;
  logic [6:0]    in_fn7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [LW-1:0] level;
  logic [15:0]   err_cnt;
  logic [2:0]    err_fmt;

  modport master (
    output flush, in_valid, in_fmt, in_opc7, in_rd, in_rs1, in_rs2, in_fn3, in_fn7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, level, err_cnt, err_fmt
  );

  modport slave (
    input  flush, in_valid, in_fmt, in_opc7, in_rd, in_rs1, in_rs2, in_fn3, in_fn7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, level, err_cnt, err_fmt
  );
endinterface

// File: rtl/ama_riscv_inst_encoder.sv
// RV32 instruction encoder: packs field requests into words, rejects unencodable immediates, queues legal words.
// Latency: word visible one cycle after acceptance; in_ready falls when the FIFO is full or during flush.
module ama_riscv_inst_encoder #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ama_riscv_inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [2:0]  err_fmt_q, err_fmt_d;

  logic [31:0] imm;
  logic [31:0] enc_inst;
  logic        enc_legal;
  logic        fits_12, fits_13, fits_21;
  logic        full, empty, accept, push, pop;

  assign imm = bus.in_imm;

  // Sign-extension checks: the discarded high bits must all equal the kept sign bit.
  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    enc_inst  = '0;
    enc_legal = 1'b0;
    case (bus.in_fmt)
      FMT_R: begin
        enc_inst  = {bus.in_fn7, bus.in_rs2, bus.in_rs1, bus.in_fn3, bus.in_rd, bus.in_opc7};
        enc_legal = 1'b1;
      end
      FMT_I: begin
        enc_inst  = {imm[11:0], bus.in_rs1, bus.in_fn3, bus.in_rd, bus.in_opc7};
        enc_legal = fits_12;
      end
      FMT_S: begin
        enc_inst  = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_fn3, imm[4:0], bus.in_opc7};
        enc_legal = fits_12;
      end
      FMT_B: begin
        enc_inst  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_fn3,
                     imm[4:1], imm[11], bus.in_opc7};
        enc_legal = fits_13 && !imm[0];
      end
      FMT_U: begin
        enc_inst  = {imm[31:12], bus.in_rd, bus.in_opc7};
        enc_legal = (imm[11:0] == 12'h000);
      end
      FMT_J: begin
        enc_inst  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opc7};
        enc_legal = fits_21 && !imm[0];
      end
      default: begin
        enc_inst  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // No bypass: a same-cycle pop never makes room for a push when full.
  assign bus.in_ready  = !full && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && enc_legal;
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  assign bus.out_valid = !empty;
  assign bus.out_inst  = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.level     = level_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_fmt   = err_fmt_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    err_cnt_d = err_cnt_q;
    err_fmt_d = err_fmt_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = enc_inst;
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    if (accept && !enc_legal) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
      err_fmt_d = bus.in_fmt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_cnt_q <= '0;
      err_fmt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
      err_fmt_q <= err_fmt_d;
    end
  end
endmodule

// File: doc/ama_riscv_inst_encoder.md
# ama_riscv_inst_encoder

Buffered RV32 instruction encoder: the inverse of the core's instruction decoder. It accepts field-level encode requests (format, opcode, registers, function bits, immediate), packs them into legal 32-bit instruction words, and rejects immediates that cannot be encoded. Legal words are queued in a small FIFO and streamed out over a valid/ready interface. It sits in the test/debug path and feeds generated instructions to the fetch/decode front end or to instruction memory.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; empties the FIFO.
- `in_valid`  in  1  encode request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready`.
- `in_fmt`  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6–7 illegal.
- `in_opc7`  in  7  major opcode, placed at bits [6:0] unchanged.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register addresses.
- `in_fn3`  in  3  funct3.
- `in_fn7`  in  7  funct7; used by R only.
- `in_imm`  in  32  immediate as a signed byte/value offset (U: full upper value).
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer ready; pop on `out_valid && out_ready`.
- `out_inst`  out  32  FIFO head instruction word.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `err_cnt`  out  16  count of rejected requests; saturates at 0xFFFF.
- `err_fmt`  out  3  `in_fmt` of the most recent rejected request.

## Operation
- Packing (fields omitted by a format are not placed):
  - R: {fn7, rs2, rs1, fn3, rd, opc7}
  - I: {imm[11:0], rs1, fn3, rd, opc7}; shift-immediates carry funct7 in imm[11:5], supplied by the caller.
  - S: {imm[11:5], rs2, rs1, fn3, imm[4:0], opc7}
  - B: {imm[12], imm[10:5], rs2, rs1, fn3, imm[4:1], imm[11], opc7}
  - U: {imm[31:12], rd, opc7}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc7}
- Legality checks:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-2^20, 2^20-2] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm is ignored. fmt 6–7 are always illegal.
- Illegal request:
  - Still consumed, i.e. the handshake completes.
  - Not enqueued.
  - `err_cnt` increments (saturating) and `err_fmt` is updated.
- FIFO:
  - Circular buffer with `DEPTH` entries; read/write pointers carry one extra wrap bit.
  - Full when the pointers are equal except for the wrap bit; empty when fully equal.
- `in_ready` = !full && !flush. There is no bypass: a pop in the same cycle does not free a slot for a push in that cycle.
- Simultaneous push and pop when not full and not empty: `level` is unchanged and both pointers advance.
- `flush`:
  - Pointers and `level` go to 0 at the next edge.
  - Any push or pop in that cycle is discarded.
  - `err_cnt` and `err_fmt` are unaffected.
- Reset (async): pointers 0, `level` 0, `out_valid` 0, `out_inst` 0, `err_cnt` 0, `err_fmt` 0. `in_ready` is 1 once `rst` deasserts. Reset mid-stream drops all queued words.

## Timing
- Encode and legality check are combinational on the request inputs. The result is registered into the FIFO on the accepting edge.
- Latency: a request accepted at edge N is visible on `out_inst` / `out_valid` after edge N (cycle N+1) if the FIFO was empty.
- Throughput: one request per cycle while not full; one pop per cycle.
- `out_inst` comes from registered storage at the read pointer. It is stable while `out_valid && !out_ready`.
- `err_cnt` and `err_fmt` update at the accepting edge of the illegal request.
- `level` is registered and reflects all pushes and pops of the prior edge.

## Test plan
- Single encodes with `out_ready`=1, each appearing one cycle after acceptance:
  - I, opc 0x13, rd 1, rs1 0, fn3 0, imm 5 -> 0x00500093
  - R, opc 0x33, rd 3, rs1 1, rs2 2 -> 0x002081B3
  - S, opc 0x23, fn3 2, rs1 1, rs2 2, imm 8 -> 0x0020A423
- Immediate scrambling:
  - B, opc 0x63, rs1 0, rs2 0, fn3 0, imm -4 -> 0xFE000EE3
  - J, opc 0x6F, rd 1, imm 8 -> 0x008000EF
  - U, opc 0x37, rd 5, imm 0x12345000 -> 0x123452B7
- Illegal requests (I imm 2048, B imm 3, U imm 0x1001, fmt 7):
  - Each is accepted but not queued; `out_valid` stays 0.
  - `err_cnt` ends at 4; `err_fmt`=7.
- Backpressure with `out_ready`=0 and 5 back-to-back legal requests (DEPTH=4):
  - `in_ready` drops after the 4th; `level`=4.
  - Releasing `out_ready` drains the words in order; the 5th is accepted on the first cycle after a slot frees.
- Simultaneous push and pop at `level`=2: `level` stays 2 and order is preserved across pointer wrap (≥10 words streamed).
- `flush` and reset:
  - `flush` with 3 queued words and concurrent `in_valid` -> `level` 0, the new request is not accepted, `err_cnt` is unchanged.
  - Asynchronous `rst` pulse mid-stream -> all outputs immediately return to their reset values.
